// File: rtl/game_link_tx_if.sv
// Message handshake between a game message source and the link transmitter.
interface game_link_tx_if;
  logic        msg_valid;
  logic [3:0]  msg_type;
  logic [11:0] msg_x;
  logic [11:0] msg_y;
  logic        msg_ready;

  modport master (output msg_valid, output msg_type, output msg_x, output msg_y,
                  input  msg_ready);
  modport slave  (input  msg_valid, input  msg_type, input  msg_x, input  msg_y,
                  output msg_ready);
endinterface

// File: rtl/game_link_tx.sv
// UART transmitter sending one 6-byte framed game packet per accepted message.
// Optional feature: define GAME_LINK_TX_PARITY_EN for 8E1 framing (even parity bit).
module game_link_tx #(
  parameter int unsigned CLK_HZ = 65_000_000,
  parameter int unsigned BAUD   = 115_200
) (
  input  logic           clk,
  input  logic           rst,
  game_link_tx_if.slave  msg,
  output logic           busy,
  output logic           tx
);

  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam int unsigned CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("game_link_tx: CLK_HZ / BAUD must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef GAME_LINK_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [3:0]    r_type;
  logic [11:0]   r_x;
  logic [11:0]   r_y;

  logic          w_ready;
  logic          w_accept;
  logic          w_tick;
  logic [7:0]    w_csum;
  logic [7:0]    w_byte;
  logic          w_tx;

  assign w_ready       = (r_state == S_IDLE);
  assign w_accept      = w_ready && msg.msg_valid;
  assign w_tick        = (r_baud == BAUD_LAST);
  assign msg.msg_ready = w_ready;
  assign busy          = ~w_ready;
  assign tx            = w_tx;

  assign w_csum = {4'h0, r_type} ^ r_x[11:4] ^ {r_x[3:0], r_y[11:8]} ^ r_y[7:0];

  always_comb begin
    w_byte = 8'hA5;
    case (r_idx)
      3'd0:    w_byte = 8'hA5;
      3'd1:    w_byte = {4'h0, r_type};
      3'd2:    w_byte = r_x[11:4];
      3'd3:    w_byte = {r_x[3:0], r_y[11:8]};
      3'd4:    w_byte = r_y[7:0];
      default: w_byte = w_csum;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        if (w_accept) begin
          w_state_nxt = S_START;
          w_idx_nxt   = '0;
          w_bit_nxt   = '0;
        end
      end
      S_START: begin
        w_baud_nxt = w_tick ? '0 : r_baud + CW'(1);
        if (w_tick) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
        end
      end
      S_DATA: begin
        w_baud_nxt = w_tick ? '0 : r_baud + CW'(1);
        if (w_tick) begin
          if (r_bit == 3'd7) begin
`ifdef GAME_LINK_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end
      end
`ifdef GAME_LINK_TX_PARITY_EN
      S_PARITY: begin
        w_baud_nxt = w_tick ? '0 : r_baud + CW'(1);
        if (w_tick) w_state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        w_baud_nxt = w_tick ? '0 : r_baud + CW'(1);
        if (w_tick) begin
          if (r_idx == 3'd5) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt   = r_idx + 3'd1;
            w_state_nxt = S_START;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Line level is decoded straight from state so reset forces idle-high at once.
  always_comb begin
    w_tx = 1'b1;
    case (r_state)
      S_START:  w_tx = 1'b0;
      S_DATA:   w_tx = w_byte[r_bit];
`ifdef GAME_LINK_TX_PARITY_EN
      S_PARITY: w_tx = ^w_byte;
`endif
      default:  w_tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_idx   <= '0;
      r_type  <= '0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_idx   <= w_idx_nxt;
      if (w_accept) begin
        r_type <= msg.msg_type;
        r_x    <= msg.msg_x;
        r_y    <= msg.msg_y;
      end
    end
  end

endmodule
